imem_loader: RTL and testbench

Boot-time loader and write-port controller for the instruction memory. It accepts a byte stream over a valid/ready handshake and packs it little-endian into 32-bit words. It drives the memory's write port (`WriteReg`, `WriteData`, `RegWrite`) one word at a time and holds the core in stall until the programmed word count has been written. It sits between the off-chip/testbench byte source and `instmemory`, and gates the core's fetch stage.

---
 rtl/imem_loader.sv | 151 +++++++++++++++
 tb/tb_imem_loader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: packs a little-endian byte stream into
// 32-bit words, drives the memory write port, and stalls the core until done.
module imem_loader #(
  parameter int DEPTH = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic [31:0]      WriteReg,
  output logic [31:0]      WriteData,
  output logic             RegWrite,
  output logic             cpu_stall,
  output logic             done,
  output logic [CNT_W-1:0] word_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_t           state_q, state_d;
  logic [1:0]       lane_q, lane_d;
  logic [23:0]      partial_q, partial_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;
  logic [31:0]      write_reg_q, write_reg_d;
  logic [31:0]      write_data_q, write_data_d;
  logic             reg_write_q, reg_write_d;
  logic             byte_ready_q, byte_ready_d;
  logic             cpu_stall_q, cpu_stall_d;
  logic             done_q, done_d;

  logic             start_ok;
  logic             accept;
  logic             last_word;
  logic [CNT_W-1:0] num_clamped;

  assign start_ok    = start && ((state_q == S_IDLE) || (state_q == S_RUN));
  assign accept      = (state_q == S_LOAD) && byte_valid && byte_ready_q;
  assign num_clamped = (num_words > DEPTH_C) ? DEPTH_C : num_words;
  assign last_word   = (word_count_q + CNT_W'(1)) == target_q;

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      lane_q       <= 2'd0;
      partial_q    <= 24'd0;
      target_q     <= '0;
      word_count_q <= '0;
      write_reg_q  <= 32'd0;
      write_data_q <= 32'd0;
      reg_write_q  <= 1'b0;
      byte_ready_q <= 1'b0;
      cpu_stall_q  <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      partial_q    <= partial_d;
      target_q     <= target_d;
      word_count_q <= word_count_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      reg_write_q  <= reg_write_d;
      byte_ready_q <= byte_ready_d;
      cpu_stall_q  <= cpu_stall_d;
      done_q       <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (start) begin
          state_d = (num_clamped == '0) ? S_RUN : S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept && (lane_q == 2'd3)) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        state_d = last_word ? S_RUN : S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; write port holds between pulses
  always_comb begin
    lane_d       = lane_q;
    partial_d    = partial_q;
    target_d     = target_q;
    word_count_d = word_count_q;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    reg_write_d  = 1'b0;
    done_d       = 1'b0;
    byte_ready_d = (state_d == S_LOAD);
    cpu_stall_d  = (state_d != S_RUN);

    if (start_ok) begin
      target_d     = num_clamped;
      word_count_d = '0;
      lane_d       = 2'd0;
      done_d       = (num_clamped == '0);
    end

    if (accept) begin
      lane_d = lane_q + 2'd1;
      case (lane_q)
        2'd0: partial_d[7:0]   = byte_in;
        2'd1: partial_d[15:8]  = byte_in;
        2'd2: partial_d[23:16] = byte_in;
        default: begin
          write_data_d = {byte_in, partial_q};
          write_reg_d  = 32'(word_count_q);
          reg_write_d  = 1'b1;
        end
      endcase
    end

    if (state_q == S_WRITE) begin
      word_count_d = word_count_q + CNT_W'(1);
      done_d       = last_word;
    end
  end

  assign byte_ready = byte_ready_q;
  assign WriteReg   = write_reg_q;
  assign WriteData  = write_data_q;
  assign RegWrite   = reg_write_q;
  assign cpu_stall  = cpu_stall_q;
  assign done       = done_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; write-port activity is logged
// on the falling edge and compared against hand-computed words.
module tb_imem_loader;

  localparam int DEPTH = 32;
  localparam int CNT_W = 6;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] num_words;
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic [31:0]      WriteReg;
  logic [31:0]      WriteData;
  logic             RegWrite;
  logic             cpu_stall;
  logic             done;
  logic [CNT_W-1:0] word_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];
  int          n_wr   = 0;
  int          n_done = 0;

  imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .num_words  (num_words),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .WriteReg   (WriteReg),
    .WriteData  (WriteData),
    .RegWrite   (RegWrite),
    .cpu_stall  (cpu_stall),
    .done       (done),
    .word_count (word_count)
  );

  always #5 clock = ~clock;

  // Write-port and done logger
  always @(negedge clock) begin
    if (RegWrite === 1'b1 && n_wr < 64) begin
      wr_addr[n_wr] = WriteReg;
      wr_data[n_wr] = WriteData;
      n_wr++;
    end
    if (done === 1'b1) n_done++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    n_checks++;
    assert (waited < 20) else begin
      n_fail++;
      $error("FAIL send_timeout: observed byte_ready=%b expected 1", byte_ready);
    end
    @(negedge clock);
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  logic [7:0] seq [8];
  int         g [4];
  int         bad_addr;
  int         bad_data;

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    num_words  = '0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    seq[0] = 8'h13; seq[1] = 8'h00; seq[2] = 8'h00; seq[3] = 8'h00;
    seq[4] = 8'hB3; seq[5] = 8'h00; seq[6] = 8'hA2; seq[7] = 8'h00;
    repeat (2) step();
    reset = 1'b0;
    step();

    // Reset defaults
    check("rst_byte_ready", byte_ready, 0);
    check("rst_regwrite",   RegWrite, 0);
    check("rst_writereg",   WriteReg, 0);
    check("rst_writedata",  WriteData, 0);
    check("rst_cpu_stall",  cpu_stall, 1);
    check("rst_done",       done, 0);
    check("rst_word_count", word_count, 0);

    // Two-word continuous load
    n_wr = 0; n_done = 0;
    start = 1'b1; num_words = 6'd2;
    step();
    start = 1'b0;
    check("two_ready_after_start", byte_ready, 1);
    check("two_stall_loading",     cpu_stall, 1);
    for (int i = 0; i < 4; i++) send_byte(seq[i]);
    check("two_w0_regwrite", RegWrite, 1);
    check("two_w0_addr",     WriteReg, 32'd0);
    check("two_w0_data",     WriteData, 32'h0000_0013);
    check("two_w0_ready",    byte_ready, 0);
    for (int i = 4; i < 8; i++) send_byte(seq[i]);
    byte_valid = 1'b0;
    check("two_w1_regwrite", RegWrite, 1);
    check("two_w1_addr",     WriteReg, 32'd1);
    check("two_w1_data",     WriteData, 32'h00A2_00B3);
    check("two_w1_no_done",  done, 0);
    check("two_w1_stall",    cpu_stall, 1);
    step();
    check("two_done",        done, 1);
    check("two_stall_low",   cpu_stall, 0);
    check("two_word_count",  word_count, 2);
    check("two_rw_low",      RegWrite, 0);
    check("two_data_hold",   WriteData, 32'h00A2_00B3);
    check("two_ready_run",   byte_ready, 0);
    step();
    check("two_done_pulse",  done, 0);
    check("two_n_writes",    n_wr, 2);
    check("two_log_addr0",   wr_addr[0], 32'd0);
    check("two_log_data0",   wr_data[0], 32'h0000_0013);
    check("two_log_addr1",   wr_addr[1], 32'd1);
    check("two_log_data1",   wr_data[1], 32'h00A2_00B3);
    check("two_n_done",      n_done, 1);

    // Gapped stream, started from RUN
    n_wr = 0; n_done = 0;
    start = 1'b1; num_words = 6'd2;
    step();
    start = 1'b0;
    check("reload_stall_rise", cpu_stall, 1);
    check("reload_count_clr",  word_count, 0);
    for (int i = 0; i < 8; i++) begin
      if (i % 4 == 0) begin
        g[1] = int'($urandom_range(0, 3));
        g[2] = int'($urandom_range(0, 3 - g[1]));
        g[3] = 3 - g[1] - g[2];
      end else begin
        byte_valid = 1'b0;
        byte_in    = 8'hFF;
        for (int k = 0; k < g[i % 4]; k++) begin
          step();
          check("gap_no_early_write", RegWrite, 0);
        end
      end
      send_byte(seq[i]);
    end
    byte_valid = 1'b0;
    step();
    check("gap_done",       done, 1);
    check("gap_word_count", word_count, 2);
    step();
    check("gap_n_writes",   n_wr, 2);
    check("gap_log_addr0",  wr_addr[0], 32'd0);
    check("gap_log_data0",  wr_data[0], 32'h0000_0013);
    check("gap_log_addr1",  wr_addr[1], 32'd1);
    check("gap_log_data1",  wr_data[1], 32'h00A2_00B3);

    // Zero-length load
    n_wr = 0; n_done = 0;
    start = 1'b1; num_words = 6'd0;
    byte_valid = 1'b1; byte_in = 8'h55;
    step();
    start = 1'b0;
    check("zero_done",       done, 1);
    check("zero_stall",      cpu_stall, 0);
    check("zero_ready",      byte_ready, 0);
    check("zero_regwrite",   RegWrite, 0);
    check("zero_word_count", word_count, 0);
    step();
    byte_valid = 1'b0;
    check("zero_done_pulse", done, 0);
    check("zero_n_writes",   n_wr, 0);

    // Clamp: 40 requested, DEPTH words written
    n_wr = 0; n_done = 0;
    start = 1'b1; num_words = 6'd40;
    step();
    start = 1'b0;
    for (int w = 0; w < 32; w++)
      for (int l = 0; l < 4; l++) send_byte(8'(w * 4 + l));
    byte_valid = 1'b0;
    step();
    check("clamp_done",       done, 1);
    check("clamp_word_count", word_count, 32);
    step();
    check("clamp_n_writes",   n_wr, 32);
    check("clamp_ready_run",  byte_ready, 0);
    bad_addr = 0; bad_data = 0;
    for (int w = 0; w < 32; w++) begin
      if (wr_addr[w] !== 32'(w)) bad_addr++;
      if (wr_data[w] !== {8'(w * 4 + 3), 8'(w * 4 + 2), 8'(w * 4 + 1), 8'(w * 4)}) bad_data++;
    end
    check("clamp_addr_errors", bad_addr, 0);
    check("clamp_data_errors", bad_data, 0);
    check("clamp_last_data",   wr_data[31], 32'h7F7E_7D7C);

    // Reset in the middle of the second word
    start = 1'b1; num_words = 6'd2;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(8'h60 + 8'(i));
    byte_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("midrst_word_count", word_count, 0);
    check("midrst_stall",      cpu_stall, 1);
    check("midrst_ready",      byte_ready, 0);
    check("midrst_writereg",   WriteReg, 0);
    check("midrst_writedata",  WriteData, 0);
    step();
    reset = 1'b0;
    n_wr = 0; n_done = 0;
    step();
    start = 1'b1; num_words = 6'd1;
    step();
    start = 1'b0;
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    byte_valid = 1'b0;
    check("fresh_regwrite", RegWrite, 1);
    check("fresh_addr",     WriteReg, 32'd0);
    check("fresh_data",     WriteData, 32'hDDCC_BBAA);
    step();
    check("fresh_done",       done, 1);
    check("fresh_word_count", word_count, 1);
    check("fresh_stall",      cpu_stall, 0);
    step();
    check("fresh_n_writes",   n_wr, 1);

    // start pulsed during LOAD is ignored
    n_wr = 0; n_done = 0;
    start = 1'b1; num_words = 6'd3;
    step();
    start = 1'b0;
    send_byte(8'h11); send_byte(8'h22);
    byte_valid = 1'b0;
    start = 1'b1; num_words = 6'd1;
    step();
    start = 1'b0;
    check("ign_word_count", word_count, 0);
    check("ign_still_load", byte_ready, 1);
    send_byte(8'h33); send_byte(8'h44);
    for (int i = 0; i < 8; i++) send_byte(8'h80 + 8'(i));
    byte_valid = 1'b0;
    step();
    check("ign_done",       done, 1);
    check("ign_word_count_end", word_count, 3);
    step();
    check("ign_n_writes",   n_wr, 3);
    check("ign_n_done",     n_done, 1);
    check("ign_data0",      wr_data[0], 32'h4433_2211);
    check("ign_data2",      wr_data[2], 32'h8786_8584);
    check("ign_addr2",      wr_addr[2], 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
